instr_fetch_ctrl: RTL

- Fetch sequencer between instruction memory and the cpu core's instruction port.
- Owns the fetch PC and issues one memory request at a time over a req/gnt/rvalid handshake.
- Buffers returned words in a small prefetch FIFO and presents them as cpu_instruction with cpu_instruction_RDY_BSY.
- On a branch/jump redirect from the core it flushes the FIFO and discards stale in-flight data.

---
 rtl/instr_fetch_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, issues one imem request at a time,
// buffers returned words in a prefetch FIFO and handles core redirects.
module instr_fetch_ctrl #(
   parameter int unsigned           ADDR_W     = 32,
   parameter int unsigned           FIFO_DEPTH = 2,
   parameter logic [ADDR_W-1:0]     RESET_PC   = '0,
   parameter int unsigned           PC_STEP    = 4
) (
   input  logic              cpu_clk,
   input  logic              cpu_rst,
   input  logic              enable,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_gnt,
   input  logic              imem_rvalid,
   input  logic [31:0]       imem_rdata,
   output logic [31:0]       cpu_instruction,
   output logic [ADDR_W-1:0] cpu_instruction_pc,
   output logic              cpu_instruction_RDY_BSY,
   input  logic              cpu_instr_ack,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

   state_t              state_q, state_d;
   logic                drop_q, drop_d;
   logic [ADDR_W-1:0]   fetch_pc_q;
   logic [ADDR_W-1:0]   entry_pc_q;
   logic [PTR_W-1:0]    rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0]    count_q, count_after;
   logic [31:0]         mem_data [FIFO_DEPTH];
   logic [ADDR_W-1:0]   mem_pc   [FIFO_DEPTH];
   logic                empty, push, pop, full_after;

   always_comb begin
      empty       = (count_q == '0);
      pop         = cpu_instr_ack && !empty && !redirect_valid;
      push        = (state_q == S_WAIT) && imem_rvalid && !drop_q && !redirect_valid;
      count_after = count_q + CNT_W'(push) - CNT_W'(pop);
      full_after  = (count_after == CNT_W'(FIFO_DEPTH));
   end

   always_ff @(posedge cpu_clk or negedge cpu_rst) begin
      if (!cpu_rst) begin
         state_q <= S_IDLE;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         drop_q  <= drop_d;
      end
   end

   always_comb begin
      state_d = state_q;
      drop_d  = drop_q;
      if (redirect_valid) begin
         // A granted or still-outstanding request must drain; its data is marked stale.
         case (state_q)
            S_REQ: begin
               if (imem_gnt) begin
                  state_d = S_WAIT;
                  drop_d  = 1'b1;
               end else begin
                  state_d = enable ? S_REQ : S_IDLE;
               end
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  drop_d  = 1'b0;
                  state_d = enable ? S_REQ : S_IDLE;
               end else begin
                  drop_d  = 1'b1;
               end
            end
            default: state_d = enable ? S_REQ : S_IDLE;
         endcase
      end else begin
         case (state_q)
            S_IDLE: begin
               if (enable) state_d = (count_q < CNT_W'(FIFO_DEPTH)) ? S_REQ : S_HOLD;
            end
            S_REQ: begin
               if (imem_gnt)     state_d = S_WAIT;
               else if (!enable) state_d = S_IDLE;
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  drop_d = 1'b0;
                  if (!enable)         state_d = S_IDLE;
                  else if (full_after) state_d = S_HOLD;
                  else                 state_d = S_REQ;
               end
            end
            S_HOLD: begin
               if (pop) state_d = enable ? S_REQ : S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge cpu_clk or negedge cpu_rst) begin
      if (!cpu_rst) begin
         fetch_pc_q <= RESET_PC;
         entry_pc_q <= '0;
      end else if (redirect_valid) begin
         fetch_pc_q <= redirect_pc;
      end else if (state_q == S_REQ && imem_gnt) begin
         fetch_pc_q <= fetch_pc_q + ADDR_W'(PC_STEP);
         entry_pc_q <= fetch_pc_q;
      end
   end

   always_ff @(posedge cpu_clk or negedge cpu_rst) begin
      if (!cpu_rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (redirect_valid) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_after;
      end
   end

   always_ff @(posedge cpu_clk) begin
      if (push) begin
         mem_data[wr_ptr_q] <= imem_rdata;
         mem_pc[wr_ptr_q]   <= entry_pc_q;
      end
   end

   always_comb begin
      imem_req                = (state_q == S_REQ);
      imem_addr               = fetch_pc_q;
      cpu_instruction_RDY_BSY = !empty;
      cpu_instruction         = empty ? '0 : mem_data[rd_ptr_q];
      cpu_instruction_pc      = empty ? '0 : mem_pc[rd_ptr_q];
   end

endmodule
